// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Bridges a multicycle controller/datapath to a ready-handshaked memory bus.
//   The bus outputs come straight from registers. Each access takes at least
//   two cycles: the request cycle in IDLE, then one or more WAIT cycles. A
//   misaligned address never reaches the bus and sets a sticky flag. A bus that
//   never answers is cut off by an 8-bit timeout, which sets a second sticky flag.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active low
//   MemReq     in   1   controller requests an access (held until Stall low)
//   IRWrite    in   1   access is an instruction fetch (result -> Instr)
//   MemWrite   in   1   access is a data store (ignored when IRWrite=1)
//   Adr        in  32   byte address
//   WriteData  in  32   store data
//   bus_rdata  in  32   read data from the bus
//   bus_ready  in   1   bus completes the current transaction this cycle
//   bus_req    out  1   registered transaction valid
//   bus_we     out  1   registered write enable
//   bus_addr   out 32   registered word address (Adr[1:0] forced to 0)
//   bus_wdata  out 32   registered store data
//   Instr      out 32   instruction register
//   Data       out 32   last completed load
//   Stall      out  1   combinational freeze for the controller FSM
//   BusErr     out  1   sticky timeout flag
//   AlignErr   out  1   sticky misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic        Stall,
  output logic        BusErr,
  output logic        AlignErr
);

  // MOV r0,r0: the instruction substituted for a fetch that failed
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q,     state_d;
  logic        bus_req_q,   bus_req_d;
  logic        bus_we_q,    bus_we_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] data_q,      data_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        fetch_q,     fetch_d;
  logic        buserr_q,    buserr_d;
  logic        alignerr_q,  alignerr_d;

  logic aligned;
  logic cnt_max;
  logic is_load;

  assign aligned = (Adr[1:0] == 2'b00);
  assign cnt_max = (cnt_q == 8'hFF);
  // The access kind is latched in IDLE. A load is neither a fetch nor a store.
  assign is_load = ~fetch_q & ~bus_we_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    instr_d     = instr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    fetch_d     = fetch_q;
    buserr_d    = buserr_q;
    alignerr_d  = alignerr_q;

    case (state_q)
      S_IDLE: begin
        // bus_ready is deliberately ignored here
        if (MemReq) begin
          if (aligned) begin
            state_d     = S_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite & ~IRWrite;
            bus_addr_d  = {Adr[31:2], 2'b00};
            bus_wdata_d = WriteData;
            fetch_d     = IRWrite;
            cnt_d       = 8'd0;
          end else begin
            alignerr_d = 1'b1;
            if (IRWrite) instr_d = NOP_INSTR;
          end
        end
      end
      S_WAIT: begin
        // Ready has priority over the timeout when both occur in the same cycle
        if (bus_ready) begin
          if (fetch_q)      instr_d = bus_rdata;
          else if (is_load) data_d  = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_max) begin
          buserr_d = 1'b1;
          if (fetch_q)      instr_d = NOP_INSTR;
          else if (is_load) data_d  = 32'd0;
          bus_req_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      instr_q     <= 32'd0;
      data_q      <= 32'd0;
      cnt_q       <= 8'd0;
      fetch_q     <= 1'b0;
      buserr_q    <= 1'b0;
      alignerr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      fetch_q     <= fetch_d;
      buserr_q    <= buserr_d;
      alignerr_q  <= alignerr_d;
    end
  end

  // Stall drops in the final WAIT cycle, whether it ends by ready or by timeout.
  // The controller therefore advances on the same edge that ends the access.
  assign Stall = ((state_q == S_IDLE) & MemReq & aligned) |
                 ((state_q == S_WAIT) & ~bus_ready & ~cnt_max);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign Instr     = instr_q;
  assign Data      = data_q;
  assign BusErr    = buserr_q;
  assign AlignErr  = alignerr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, IRWrite, MemWrite, bus_ready;
  logic [31:0] Adr, WriteData, bus_rdata;
  logic        bus_req, bus_we, Stall, BusErr, AlignErr;
  logic [31:0] bus_addr, bus_wdata, Instr, Data;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .Instr(Instr), .Data(Data), .Stall(Stall), .BusErr(BusErr),
    .AlignErr(AlignErr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    MemReq = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0;
    Adr = 32'd0; WriteData = 32'd0; bus_rdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
    total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
    total++; if (bus_addr !== 32'd0) begin bad++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
    total++; if (bus_wdata !== 32'd0) begin bad++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
    total++; if (Instr !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h want 0", Instr); end
    total++; if (Data !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", Data); end
    total++; if ({BusErr, AlignErr, Stall} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {BusErr, AlignErr, Stall}); end
    reset = 1'b1;
    step();
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_release_idle: got %b want 0", bus_req); end
  endtask

  task automatic test_fetch_zero_wait();
    MemReq = 1'b1; IRWrite = 1'b1; Adr = 32'h100;
    #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_idle: got %b want 1", Stall); end
    step();
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0) begin bad++; $display("FAIL fetch_bus: got req=%b we=%b addr=%h want 1 0 00000100", bus_req, bus_we, bus_addr); end
    bus_ready = 1'b1; bus_rdata = 32'hE3A01005;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_ready: got %b want 0", Stall); end
    step();
    MemReq = 1'b0; IRWrite = 1'b0; bus_ready = 1'b0;
    total++; if (Instr !== 32'hE3A01005) begin bad++; $display("FAIL fetch_instr: got %h want e3a01005", Instr); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL fetch_done_req: got %b want 0", bus_req); end
  endtask

  task automatic test_load_churn();
    MemReq = 1'b1; Adr = 32'h300; WriteData = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) begin
        Adr = 32'h300 + 32'(k * 4) + 32'd1;
        WriteData = 32'(k) * 32'h01010101;
        MemWrite = k[0];
        MemReq = (k != 2);
        bus_ready = (k == 3);
        bus_rdata = 32'h12345678;
        #1;
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h300 || bus_wdata !== 32'h11111111) begin
          bad++; $display("FAIL churn_hold: got req=%b we=%b addr=%h wdata=%h want 1 0 00000300 11111111", bus_req, bus_we, bus_addr, bus_wdata);
        end
      end
      step();
    end
    idle_inputs();
    total++; if (Data !== 32'h12345678) begin bad++; $display("FAIL load_data: got %h want 12345678", Data); end
    total++; if (Instr !== 32'hE3A01005) begin bad++; $display("FAIL load_instr_kept: got %h want e3a01005", Instr); end
  endtask

  task automatic test_store_wait3();
    int stalls = 0;
    MemReq = 1'b1; MemWrite = 1'b1; Adr = 32'h204; WriteData = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      bus_ready = (k == 4);
      bus_rdata = 32'hBAD0BAD0;
      #1;
      if (Stall) stalls++;
      if (k >= 1) begin
        total++; if (bus_we !== 1'b1 || bus_wdata !== 32'hDEADBEEF || bus_addr !== 32'h204) begin
          bad++; $display("FAIL store_bus: got we=%b wdata=%h addr=%h want 1 deadbeef 00000204", bus_we, bus_wdata, bus_addr);
        end
      end
      step();
    end
    idle_inputs();
    total++; if (stalls != 4) begin bad++; $display("FAIL store_stall_cycles: got %0d want 4", stalls); end
    total++; if (Data !== 32'h12345678 || Instr !== 32'hE3A01005) begin bad++; $display("FAIL store_regs_kept: got data=%h instr=%h want 12345678 e3a01005", Data, Instr); end
    total++; if ({BusErr, AlignErr} !== 2'b00) begin bad++; $display("FAIL store_flags: got %b want 00", {BusErr, AlignErr}); end
  endtask

  task automatic test_misaligned();
    MemReq = 1'b1; IRWrite = 1'b1; Adr = 32'h102;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", Stall); end
    step();
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL mis_bus_req: got %b want 0", bus_req); end
    total++; if (AlignErr !== 1'b1) begin bad++; $display("FAIL mis_alignerr: got %b want 1", AlignErr); end
    total++; if (Instr !== 32'hE1A00000) begin bad++; $display("FAIL mis_instr: got %h want e1a00000", Instr); end
    // misaligned load leaves Data alone
    IRWrite = 1'b0; Adr = 32'h301;
    step();
    idle_inputs();
    total++; if (Data !== 32'h12345678 || bus_req !== 1'b0) begin bad++; $display("FAIL mis_load: got data=%h req=%b want 12345678 0", Data, bus_req); end
  endtask

  // Ready arrives in the cycle where the counter sits at 255
  task automatic test_ready_at_limit();
    int stalls = 0;
    int waits = 0;
    MemReq = 1'b1; Adr = 32'h404; bus_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 300; k++) begin
      bus_ready = bus_req && (waits == 255);
      #1;
      if (Stall) stalls++;
      if (bus_req) waits++;
      step();
      if (k > 0 && !bus_req) break;
    end
    idle_inputs();
    total++; if (waits != 256 || stalls != 256) begin bad++; $display("FAIL limit_cycles: got waits=%0d stalls=%0d want 256 256", waits, stalls); end
    total++; if (Data !== 32'hCAFEF00D) begin bad++; $display("FAIL limit_data: got %h want cafef00d", Data); end
    total++; if (BusErr !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL limit_buserr: got err=%b req=%b want 0 0", BusErr, bus_req); end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int waits = 0;
    MemReq = 1'b1; Adr = 32'h400;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (Stall) stalls++;
      if (bus_req) waits++;
      step();
      if (k > 0 && !bus_req) break;
    end
    idle_inputs();
    total++; if (waits != 256 || stalls != 256) begin bad++; $display("FAIL to_cycles: got waits=%0d stalls=%0d want 256 256", waits, stalls); end
    total++; if (Data !== 32'd0 || BusErr !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL to_result: got data=%h err=%b req=%b want 0 1 0", Data, BusErr, bus_req); end
    // a good fetch afterwards leaves BusErr set
    MemReq = 1'b1; IRWrite = 1'b1; Adr = 32'h108;
    step();
    bus_ready = 1'b1; bus_rdata = 32'hE2811001;
    step();
    idle_inputs();
    total++; if (Instr !== 32'hE2811001 || BusErr !== 1'b1) begin bad++; $display("FAIL to_sticky: got instr=%h err=%b want e2811001 1", Instr, BusErr); end
  endtask

  task automatic test_back_to_back();
    MemReq = 1'b1; IRWrite = 1'b1; Adr = 32'h500;
    step();
    bus_ready = 1'b1; bus_rdata = 32'hAAAA0001;
    step();
    bus_ready = 1'b0; Adr = 32'h504;
    #1;
    total++; if (Instr !== 32'hAAAA0001 || bus_req !== 1'b0 || Stall !== 1'b1) begin bad++; $display("FAIL b2b_gap: got instr=%h req=%b stall=%b want aaaa0001 0 1", Instr, bus_req, Stall); end
    step();
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h504) begin bad++; $display("FAIL b2b_second: got req=%b addr=%h want 1 00000504", bus_req, bus_addr); end
    bus_ready = 1'b1; bus_rdata = 32'hBBBB0002;
    step();
    idle_inputs();
    total++; if (Instr !== 32'hBBBB0002) begin bad++; $display("FAIL b2b_instr: got %h want bbbb0002", Instr); end
  endtask

  task automatic test_reset_mid_wait();
    MemReq = 1'b1; Adr = 32'h600;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0 || Instr !== 32'd0 || Data !== 32'd0) begin bad++; $display("FAIL rmw_async: got req=%b instr=%h data=%h want 0 0 0", bus_req, Instr, Data); end
    total++; if ({BusErr, AlignErr} !== 2'b00) begin bad++; $display("FAIL rmw_flags: got %b want 00", {BusErr, AlignErr}); end
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL rmw_stall_idle_req: got %b want 1", Stall); end
    MemReq = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'h99999999;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rmw_stall: got %b want 0", Stall); end
    step();
    reset = 1'b1;
    step();
    step();
    idle_inputs();
    total++; if (Data !== 32'd0 || Instr !== 32'd0 || bus_req !== 1'b0) begin bad++; $display("FAIL rmw_no_capture: got data=%h instr=%h req=%b want 0 0 0", Data, Instr, bus_req); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fetch_zero_wait();
    test_load_churn();
    test_store_wait3();
    test_misaligned();
    test_ready_at_limit();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port MemReq  input  1  controller requests one memory access; held high until Stall is low.
REQ-004 SHALL have port IRWrite  input  1  access is an instruction fetch; result goes to Instr.
REQ-005 SHALL have port MemWrite  input  1  access is a data write; ignored when IRWrite=1.
REQ-006 SHALL have port Adr  input  32  byte address from datapath.
REQ-007 SHALL have port WriteData  input  32  store data.
REQ-008 SHALL have port bus_rdata  input  32  read data from memory bus.
REQ-009 SHALL have port bus_ready  input  1  memory bus completes current transaction this cycle.
REQ-010 SHALL have port bus_req  output  1  registered transaction-valid to memory bus.
REQ-011 SHALL have port bus_we  output  1  registered write-enable to memory bus.
REQ-012 SHALL have port bus_addr  output  32  registered word address (Adr with [1:0] forced to 0).
REQ-013 SHALL have port bus_wdata  output  32  registered store data.
REQ-014 SHALL have port Instr  output  32  instruction register feeding controller and datapath.
REQ-015 SHALL have port Data  output  32  data register holding last completed load.
REQ-016 SHALL have port Stall  output  1  combinational; freezes controller FSM while high.
REQ-017 SHALL have port BusErr  output  1  sticky timeout flag.
REQ-018 SHALL have port AlignErr  output  1  sticky misaligned-access flag.

Function
REQ-019 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-020 In IDLE with MemReq=1 and Adr[1:0]=00: next edge latches bus_addr, bus_we (MemWrite & ~IRWrite), bus_wdata, the fetch/load kind, sets bus_req=1, clears timeout counter, enters WAIT.
REQ-021 In IDLE with MemReq=1 and Adr[1:0]!=00: no bus transaction; next edge sets AlignErr=1; fetch loads Instr=0xE1A00000, load leaves Data unchanged; stays IDLE.
REQ-022 Stall SHALL equal (IDLE & MemReq & Adr[1:0]=00) | (WAIT & ~bus_ready & counter!=255).
REQ-023 In WAIT, bus_addr/bus_we/bus_wdata/bus_req SHALL hold constant; changes on Adr, WriteData, MemWrite, MemReq ignored.
REQ-024 In WAIT with bus_ready=1: next edge captures bus_rdata into Instr (fetch) or Data (load), nothing for writes; bus_req->0; enters IDLE.
REQ-025 Minimum access latency SHALL be 2 cycles (request cycle + one WAIT cycle with bus_ready=1); controller advances on the second edge.
REQ-026 8-bit timeout counter SHALL increment each WAIT cycle without bus_ready, saturating at 255.
REQ-027 In WAIT with counter=255 and bus_ready=0: next edge terminates access, sets BusErr=1, loads Instr=0xE1A00000 (fetch) or Data=0 (load), bus_req->0, enters IDLE.
REQ-028 bus_ready and counter=255 in same cycle SHALL be treated as normal completion (ready wins, BusErr unchanged).
REQ-029 bus_ready while in IDLE SHALL be ignored.
REQ-030 BusErr and AlignErr SHALL remain 1 until reset.
REQ-031 Back-to-back: MemReq held high after completion SHALL start a new access from IDLE on the following cycle (one IDLE cycle between transactions).

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, Instr=0, Data=0, counter=0, BusErr=0, AlignErr=0, regardless of clk.
REQ-033 Reset asserted mid-WAIT SHALL abandon the transaction with no register capture; Stall follows REQ-022 from reset values.
REQ-034 Deassertion of reset SHALL take effect at the first rising edge after reset=1.

Verification
REQ-035 Fetch, zero wait: MemReq=1, IRWrite=1, Adr=0x100, bus_ready=1 in first WAIT cycle, bus_rdata=0xE3A01005 -> bus_addr=0x100, Stall high 1 cycle, Instr=0xE3A01005 after 2nd edge.
REQ-036 Store, 3 wait states: MemWrite=1, Adr=0x204, WriteData=0xDEADBEEF, bus_ready after 3 WAIT cycles -> bus_we=1, bus_wdata=0xDEADBEEF stable, Stall high 4 cycles, Data unchanged.
REQ-037 Timeout: load, bus_ready never asserted -> counter reaches 255, access ends, Data=0, BusErr=1 and stays 1 through subsequent good accesses.
REQ-038 Misaligned fetch: Adr=0x102 -> bus_req stays 0, Stall=0, AlignErr=1, Instr=0xE1A00000.
REQ-039 Reset mid-WAIT: reset=0 during 2nd WAIT cycle -> bus_req=0 asynchronously, Instr/Data=0, later bus_ready with data causes no capture.
REQ-040 Input churn: change Adr/WriteData every cycle during WAIT -> bus_addr/bus_wdata hold first-latched values.
